nmr_voter_recovery: RTL
=======================

Name: nmr_voter_recovery

Overview:
- Parametrised N-modular-redundancy voter with fault bookkeeping and a recovery state machine; successor to the fixed three-core voter/lockstep pair.
- Sits between NUM_CORES lockstepped RISC-V cores and the shared data memory / instruction fetch path.
- Votes each core's commit bundle (PC, ALUResult, RD2, MemWrite) and keeps a saturating fault count per core.
- Permanently masks a core that reaches the fault threshold, degrading TMR to DMR; sequences hold and resync after every masked fault.

Parameters:
- NUM_CORES, 3, number of redundant cores; odd, 3..7.
- DATA_W, 97, bundle width; {MemWrite[96], RD2[95:64], ALUResult[63:32], PC[31:0]}.
- FAULT_THRESH, 4, fault count at which a core is disabled; 1..2^CNT_W-1.
- HOLD_CYCLES, 8, cycles core_hold stays high before resync; >=1.
- CNT_W, 8, width of each fault counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_in  in  1  asynchronous active-low reset.
- valid_in  in  1  cores present a commit bundle this cycle.
- core_bus_in  in  NUM_CORES*DATA_W  core i bundle at [i*DATA_W +: DATA_W].
- clr_faults  in  1  clear counters and re-enable all cores; honoured only in RUN.
- voted_out  out  DATA_W  registered voted bundle.
- voted_valid  out  1  voted_out valid this cycle.
- mismatch_vec  out  NUM_CORES  registered per-core disagreement flags for the last vote.
- core_enable  out  NUM_CORES  cores participating in the vote.
- core_hold  out  1  stall all cores.
- resync_req  out  1  one-cycle pulse: copy architectural state from resync_src.
- resync_src  out  $clog2(NUM_CORES)  index of the donor core.
- fault_cnt_flat  out  NUM_CORES*CNT_W  per-core saturating fault counters.
- halted  out  1  unrecoverable state.

Behaviour:
- Reset (rst_in=0, async): voted_out=0, voted_valid=0, mismatch_vec=0, core_enable=all 1, core_hold=0, resync_req=0, resync_src=0, fault counters=0, halted=0, state=RUN.
- Vote (combinational, registered output):
  - E = popcount(core_enable).
  - Per bit: ones = count of enabled cores driving 1; voted bit = (2*ones > E).
  - Tie on any bit (2*ones == E) → no_majority.
  - Disabled cores are excluded from both the count and the comparison.
- Latency: voted_out, voted_valid and mismatch_vec update 1 cycle after valid_in is sampled.
  - voted_valid=1 for an accepted valid_in with a majority, including the faulting cycle; the fault is masked.
- mismatch_vec[i] = core_enable[i] & (bundle_i != voted word). Disabled cores always read 0.
- States: RUN, HOLD, RESYNC, HALT. valid_in is ignored outside RUN.
- RUN:
  - valid_in & no_majority → HALT; voted_valid stays 0.
  - valid_in & majority & any mismatch:
    - Increment each mismatching core's counter, saturating at 2^CNT_W-1.
    - A counter whose new value is >= FAULT_THRESH clears its core_enable on the same edge.
    - Go to HOLD; load hold counter = HOLD_CYCLES-1; core_hold=1 from the next cycle.
    - Latch resync_src = lowest-index enabled core with no mismatch.
  - If E after disabling would be < 2 → HALT instead of HOLD.
  - clr_faults: counters=0, core_enable=all 1. If it coincides with a fault, the fault is processed and clr_faults is dropped.
- HOLD: core_hold=1; decrement hold counter; at 0 → RESYNC.
- RESYNC: core_hold=1, resync_req=1 for exactly one cycle, then RUN. core_hold drops on RUN entry.
- HALT: core_hold=1, halted=1, voted_valid=0. Only reset exits.
- Counter arithmetic: unsigned CNT_W; the saturating increment never wraps.
- Asynchronous reset mid-HOLD/RESYNC returns every output to its reset value immediately. A resync_req pulse in progress is aborted.

Decomposition:
- Shared package nmr_pkg:
  - state encoding (RUN=2'd0, HOLD=2'd1, RESYNC=2'd2, HALT=2'd3);
  - bundle field offsets (PC_LSB=0, ALU_LSB=32, RD2_LSB=64, MEMWRITE_BIT=96).
- One sub-module, majority_vote: combinational per-bit masked majority over NUM_CORES inputs. Outputs the voted word and a tie flag. Reused by any future voter.

Test Plan:
- No fault: 3 cores, identical bundles PC=0x10, valid_in=1 → next cycle voted_out PC=0x10, voted_valid=1, mismatch_vec=000, core_hold stays 0.
- Single fault: core1 ALUResult=0xDEAD, others 0xBEEF → voted ALU=0xBEEF, mismatch_vec=010, cnt1=1, core_hold high 9 cycles, resync_req pulse on cycle 9 with resync_src=0.
- Degradation: inject core2 faults 4 times (FAULT_THRESH=4) → after the 4th, core_enable=011. Then core0≠core1 on one bit → tie → halted=1, voted_valid=0.
- Saturation: CNT_W=2, FAULT_THRESH=3, NUM_CORES=5, repeated core4 faults → cnt4 stops at 3, core_enable[4]=0, never wraps.
- clr_faults: after core2 disabled, assert clr_faults in RUN → counters 0, core_enable=111. The same request coincident with a fault → fault processed, clear ignored.
- Reset mid-HOLD: drop rst_in on hold cycle 3 → core_hold=0, state RUN, counters 0 immediately without a clock edge.

Source files
------------

// File: rtl/nmr_pkg.sv
// Shared definitions for the N-modular-redundancy voter family.
//   - nmr_state_e : recovery state encoding (RUN, HOLD, RESYNC, HALT)
//   - *_LSB / MEMWRITE_BIT : field offsets inside a 97-bit commit bundle
//   - popcount8   : number of set bits in an (up to) 8-bit enable mask
package nmr_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    RESYNC = 2'd2,
    HALT   = 2'd3
  } nmr_state_e;

  localparam int PC_LSB       = 0;
  localparam int ALU_LSB      = 32;
  localparam int RD2_LSB      = 64;
  localparam int MEMWRITE_BIT = 96;

  // Core masks never exceed 8 bits (NUM_CORES <= 7), so callers zero-extend.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nmr_voter_recovery_if.sv
// Bus between the redundant cores (master side) and the voter (slave side).
//   master drives : valid_in, core_bus_in, clr_faults
//   slave drives  : voted_out, voted_valid, mismatch_vec, core_enable,
//                   core_hold, resync_req, resync_src, fault_cnt_flat, halted
interface nmr_voter_recovery_if #(
  parameter int NUM_CORES = 3,
  parameter int DATA_W    = 97,
  parameter int CNT_W     = 8
);
  localparam int SRC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                          valid_in;
  logic [NUM_CORES*DATA_W-1:0]   core_bus_in;
  logic                          clr_faults;
  logic [DATA_W-1:0]             voted_out;
  logic                          voted_valid;
  logic [NUM_CORES-1:0]          mismatch_vec;
  logic [NUM_CORES-1:0]          core_enable;
  logic                          core_hold;
  logic                          resync_req;
  logic [SRC_W-1:0]              resync_src;
  logic [NUM_CORES*CNT_W-1:0]    fault_cnt_flat;
  logic                          halted;

  modport master (
    output valid_in, core_bus_in, clr_faults,
    input  voted_out, voted_valid, mismatch_vec, core_enable, core_hold,
           resync_req, resync_src, fault_cnt_flat, halted
  );

  modport slave (
    input  valid_in, core_bus_in, clr_faults,
    output voted_out, voted_valid, mismatch_vec, core_enable, core_hold,
           resync_req, resync_src, fault_cnt_flat, halted
  );
endinterface

// File: rtl/nmr_voter_recovery_majority_vote.sv
// Combinational per-bit masked majority over NUM_CORES words.
//   i_bus    : word c at [c*DATA_W +: DATA_W]
//   i_enable : only enabled words are counted
//   o_word   : bit = 1 when strictly more than half of the enabled words drive 1
//   o_tie    : some bit has exactly half of the enabled words driving 1
module majority_vote #(
  parameter int NUM_CORES = 3,
  parameter int DATA_W    = 97
) (
  input  logic [NUM_CORES*DATA_W-1:0] i_bus,
  input  logic [NUM_CORES-1:0]        i_enable,
  output logic [DATA_W-1:0]           o_word,
  output logic                        o_tie
);
  localparam int CW = $clog2(NUM_CORES + 1) + 1;

  logic [CW-1:0] w_en_cnt;
  logic [CW-1:0] w_ones;
  logic [CW:0]   w_twice;

  // Count enabled cores, then per bit compare 2*ones against that count.
  always_comb begin
    w_en_cnt = '0;
    w_ones   = '0;
    w_twice  = '0;
    o_word   = '0;
    o_tie    = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      w_en_cnt = w_en_cnt + CW'(i_enable[c]);
    end
    for (int b = 0; b < DATA_W; b++) begin
      w_ones = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        w_ones = w_ones + CW'(i_enable[c] & i_bus[c*DATA_W + b]);
      end
      w_twice   = {w_ones, 1'b0};
      o_word[b] = (w_twice > {1'b0, w_en_cnt});
      if (w_twice == {1'b0, w_en_cnt}) begin
        o_tie = 1'b1;
      end else begin
        o_tie = o_tie;
      end
    end
  end
endmodule

// File: rtl/nmr_voter_recovery.sv
// NMR voter with per-core saturating fault counters and a recovery FSM.
//   clk   : rising-edge clock
//   rst_in: asynchronous active-low reset
//   bus   : slave side of nmr_voter_recovery_if (commit bundles in,
//           voted bundle / fault bookkeeping / hold+resync control out)
// A vote with a majority but some dissenting cores masks the fault, bumps the
// dissenters' counters, disables any that reach FAULT_THRESH, then stalls the
// cores for HOLD_CYCLES and pulses resync_req from a healthy donor core.
module nmr_voter_recovery
  import nmr_pkg::*;
#(
  parameter int NUM_CORES    = 3,
  parameter int DATA_W       = 97,
  parameter int FAULT_THRESH = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int CNT_W        = 8
) (
  input  logic           clk,
  input  logic           rst_in,
  nmr_voter_recovery_if.slave bus
);
  localparam int SRC_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

  nmr_state_e                       r_state;
  logic [DATA_W-1:0]                r_voted_out;
  logic                             r_voted_valid;
  logic [NUM_CORES-1:0]             r_mismatch_vec;
  logic [NUM_CORES-1:0]             r_core_enable;
  logic                             r_core_hold;
  logic                             r_resync_req;
  logic [SRC_W-1:0]                 r_resync_src;
  logic [NUM_CORES-1:0][CNT_W-1:0]  r_fault_cnt;
  logic                             r_halted;
  logic [HOLD_W-1:0]                r_hold_cnt;

  logic [DATA_W-1:0]                w_vote;
  logic                             w_tie;
  logic [DATA_W-1:0]                w_bundle;
  logic [NUM_CORES-1:0]             w_mismatch;
  logic [NUM_CORES-1:0][CNT_W-1:0]  w_cnt_next;
  logic [NUM_CORES-1:0]             w_en_next;
  logic [3:0]                       w_en_after;
  logic [SRC_W-1:0]                 w_src;
  logic                             w_src_found;

  majority_vote #(
    .NUM_CORES (NUM_CORES),
    .DATA_W    (DATA_W)
  ) u_vote (
    .i_bus    (bus.core_bus_in),
    .i_enable (r_core_enable),
    .o_word   (w_vote),
    .o_tie    (w_tie)
  );

  // Per-core disagreement, next counter/enable values and donor selection.
  always_comb begin
    w_bundle    = '0;
    w_mismatch  = '0;
    w_cnt_next  = r_fault_cnt;
    w_en_next   = r_core_enable;
    w_src       = '0;
    w_src_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_bundle      = bus.core_bus_in[i*DATA_W +: DATA_W];
      w_mismatch[i] = r_core_enable[i] & (w_bundle != w_vote);
      if (w_mismatch[i]) begin
        // Saturate rather than wrap so a stuck core can never look healthy.
        w_cnt_next[i] = (r_fault_cnt[i] == CNT_MAX) ? r_fault_cnt[i]
                                                    : r_fault_cnt[i] + CNT_W'(1);
        w_en_next[i]  = (w_cnt_next[i] >= THRESH) ? 1'b0 : r_core_enable[i];
      end else begin
        w_cnt_next[i] = r_fault_cnt[i];
        w_en_next[i]  = r_core_enable[i];
      end
      // Donor is the lowest-index core that is enabled and agreed with the vote.
      if (!w_src_found && r_core_enable[i] && !w_mismatch[i]) begin
        w_src       = SRC_W'(i);
        w_src_found = 1'b1;
      end else begin
        w_src_found = w_src_found;
      end
    end
    w_en_after = popcount8(8'(w_en_next));
  end

  // Recovery FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= RUN;
      r_voted_out    <= '0;
      r_voted_valid  <= 1'b0;
      r_mismatch_vec <= '0;
      r_core_enable  <= {NUM_CORES{1'b1}};
      r_core_hold    <= 1'b0;
      r_resync_req   <= 1'b0;
      r_resync_src   <= '0;
      r_fault_cnt    <= '0;
      r_halted       <= 1'b0;
      r_hold_cnt     <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_core_hold  <= 1'b0;
          r_resync_req <= 1'b0;
          if (bus.valid_in) begin
            r_mismatch_vec <= w_mismatch;
            if (w_tie) begin
              r_state       <= HALT;
              r_voted_valid <= 1'b0;
              r_core_hold   <= 1'b1;
              r_halted      <= 1'b1;
            end else if (|w_mismatch) begin
              // A fault takes priority over a coincident clear request.
              r_voted_out   <= w_vote;
              r_fault_cnt   <= w_cnt_next;
              r_core_enable <= w_en_next;
              r_resync_src  <= w_src;
              r_core_hold   <= 1'b1;
              if (w_en_after < 4'd2) begin
                r_state       <= HALT;
                r_voted_valid <= 1'b0;
                r_halted      <= 1'b1;
              end else begin
                r_state       <= HOLD;
                r_voted_valid <= 1'b1;
                r_hold_cnt    <= HOLD_W'(HOLD_CYCLES - 1);
              end
            end else begin
              r_voted_out   <= w_vote;
              r_voted_valid <= 1'b1;
              if (bus.clr_faults) begin
                r_fault_cnt   <= '0;
                r_core_enable <= {NUM_CORES{1'b1}};
              end else begin
                r_fault_cnt   <= r_fault_cnt;
              end
            end
          end else begin
            r_voted_valid <= 1'b0;
            if (bus.clr_faults) begin
              r_fault_cnt   <= '0;
              r_core_enable <= {NUM_CORES{1'b1}};
            end else begin
              r_fault_cnt   <= r_fault_cnt;
            end
          end
        end
        HOLD: begin
          r_voted_valid <= 1'b0;
          r_core_hold   <= 1'b1;
          if (r_hold_cnt == '0) begin
            r_state      <= RESYNC;
            r_resync_req <= 1'b1;
          end else begin
            r_hold_cnt   <= r_hold_cnt - HOLD_W'(1);
          end
        end
        RESYNC: begin
          r_voted_valid <= 1'b0;
          r_resync_req  <= 1'b0;
          r_core_hold   <= 1'b0;
          r_state       <= RUN;
        end
        HALT: begin
          r_voted_valid <= 1'b0;
          r_resync_req  <= 1'b0;
          r_core_hold   <= 1'b1;
          r_halted      <= 1'b1;
        end
        default: begin
          r_state       <= HALT;
          r_voted_valid <= 1'b0;
          r_core_hold   <= 1'b1;
          r_halted      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.voted_out      = r_voted_out;
  assign bus.voted_valid    = r_voted_valid;
  assign bus.mismatch_vec   = r_mismatch_vec;
  assign bus.core_enable    = r_core_enable;
  assign bus.core_hold      = r_core_hold;
  assign bus.resync_req     = r_resync_req;
  assign bus.resync_src     = r_resync_src;
  assign bus.fault_cnt_flat = r_fault_cnt;
  assign bus.halted         = r_halted;

endmodule
